// File: rtl/md_unit.sv
// Multiply/divide/accumulate unit with HI/LO registers for the EX stage.
// Results are computed at capture time and committed after a fixed busy latency.
module md_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       start,
  input  logic             req,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MUL_N = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_N = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CW-1:0]        r_cnt;
  logic                 r_done;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [2*WIDTH-1:0]   r_res;

  logic [2*WIDTH-1:0]   w_acc;
  logic [2*WIDTH-1:0]   w_sprod;
  logic [2*WIDTH-1:0]   w_uprod;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_dvd;
  logic [WIDTH-1:0]     w_dvs;
  logic [WIDTH-1:0]     w_uq;
  logic [WIDTH-1:0]     w_ur;
  logic [WIDTH-1:0]     w_q;
  logic [WIDTH-1:0]     w_r;
  logic [2*WIDTH-1:0]   w_res;
  logic                 w_commit;

  assign w_acc   = {r_hi, r_lo};
  assign w_sprod = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
  assign w_uprod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

  // One unsigned divider serves both div and divu; signed div works on magnitudes.
  // Most-negative / -1 falls out naturally: quotient magnitude 2^(W-1) negates to itself.
  assign w_a_neg = (start == OP_DIV) & A[WIDTH-1];
  assign w_b_neg = (start == OP_DIV) & B[WIDTH-1];
  assign w_dvd   = w_a_neg ? ({WIDTH{1'b0}} - A) : A;
  assign w_dvs   = w_b_neg ? ({WIDTH{1'b0}} - B) : B;
  assign w_uq    = w_dvd / w_dvs;
  assign w_ur    = w_dvd % w_dvs;
  assign w_q     = (w_a_neg ^ w_b_neg) ? ({WIDTH{1'b0}} - w_uq) : w_uq;
  assign w_r     = w_a_neg ? ({WIDTH{1'b0}} - w_ur) : w_ur;

  assign w_commit = (r_state == S_BUSY) && !req && (r_cnt == CNT_ONE);

  // Result selection for the op being captured this cycle.
  always_comb begin
    w_res = w_acc;
    case (start)
      OP_MULT:  w_res = w_sprod;
      OP_MULTU: w_res = w_uprod;
      OP_MADD:  w_res = w_acc + w_sprod;
      OP_MADDU: w_res = w_acc + w_uprod;
      OP_MSUB:  w_res = w_acc - w_sprod;
      OP_MSUBU: w_res = w_acc - w_uprod;
      OP_DIV, OP_DIVU: begin
        if (B == {WIDTH{1'b0}}) begin
          w_res = {A, {WIDTH{1'b1}}};
        end else begin
          w_res = {w_r, w_q};
        end
      end
      default: w_res = w_acc;
    endcase
  end

  // Next-state logic: cancel wins over completion.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!req && (start inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
                                   OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU})) begin
          w_next = S_BUSY;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_BUSY: begin
        if (req || (r_cnt == CNT_ONE)) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_BUSY;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Capture, countdown, commit and HI/LO writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt  <= {CW{1'b0}};
      r_done <= 1'b0;
      r_hi   <= {WIDTH{1'b0}};
      r_lo   <= {WIDTH{1'b0}};
      r_res  <= {(2*WIDTH){1'b0}};
    end else begin
      r_done <= w_commit;
      if (r_state == S_IDLE && !req) begin
        case (start)
          OP_MTHI: r_hi <= A;
          OP_MTLO: r_lo <= A;
          OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
            r_res <= w_res;
            r_cnt <= MUL_N;
          end
          OP_DIV, OP_DIVU: begin
            r_res <= w_res;
            r_cnt <= DIV_N;
          end
          default: ;
        endcase
      end else if (r_state == S_BUSY) begin
        if (req) begin
          r_cnt <= {CW{1'b0}};
        end else begin
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            {r_hi, r_lo} <= r_res;
          end
        end
      end
    end
  end

  assign busy = (r_state == S_BUSY);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
